// File: rtl/merv32_bus_pkg.sv
// merv32_bus_pkg
// Shared types and constants for the merv32 bus arbiter:
//   HTRANS_IDLE / HTRANS_NONSEQ : AHB-Lite transfer type encodings
//   state_e                     : arbiter FSM states
//   owner_e                     : which requester owns the current transfer
package merv32_bus_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  typedef enum logic {OWN_I, OWN_D} owner_e;

endpackage

// File: rtl/merv32_bus_timer.sv
// merv32_bus_timer
// 8-bit data-phase watchdog. Counts cycles while en_i is high; expire_o is
// raised combinationally in the cycle whose edge would bring the count to
// TIMEOUT, so the owner can complete on that same edge.
// Ports:
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   en_i     : count this cycle (data phase with bus not ready)
//   clr_i    : clear the count (transfer completed)
//   expire_o : limit reached on this edge (never set when TIMEOUT == 0)
module merv32_bus_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam bit         ENABLED = (TIMEOUT != 0);
  localparam logic [7:0] LAST    = 8'(TIMEOUT - 1);

  logic [7:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) count_q <= '0;
    else if (en_i)      count_q <= count_q + 8'd1;
  end

  assign expire_o = ENABLED && en_i && (count_q == LAST);

endmodule

// File: rtl/merv32_bus_arbiter.sv
// merv32_bus_arbiter
// Shares one AHB-Lite master port between the merv32 fetch (i_*) and
// load/store (d_*) requesters. Data has fixed priority, except that after
// STARVE_LIMIT consecutive data grants won against a pending fetch, the
// fetch is granted. One transfer outstanding; every output is registered.
// Ports:
//   ma_riscv32_rp_clk_in / ms_riscv32_mp_rst_in : clock, sync active-high reset
//   i_req_in/i_addr_in -> i_rdata_out/i_hready_out/i_err_out : fetch side
//   d_req_in/d_addr_in/d_wr_in/d_wdata_in/d_mask_in
//     -> d_rdata_out/d_hready_out/d_err_out                  : data side
//   haddr_out/htrans_out/hwrite_out/hwdata_out/hstrb_out      : bus request
//   hrdata_in/hready_in/hresp_in                              : bus response
module merv32_bus_arbiter
  import merv32_bus_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        ma_riscv32_rp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        i_req_in,
  input  logic [31:0] i_addr_in,
  output logic [31:0] i_rdata_out,
  output logic        i_hready_out,
  output logic        i_err_out,
  input  logic        d_req_in,
  input  logic [31:0] d_addr_in,
  input  logic        d_wr_in,
  input  logic [31:0] d_wdata_in,
  input  logic [3:0]  d_mask_in,
  output logic [31:0] d_rdata_out,
  output logic        d_hready_out,
  output logic        d_err_out,
  output logic [31:0] haddr_out,
  output logic [1:0]  htrans_out,
  output logic        hwrite_out,
  output logic [31:0] hwdata_out,
  output logic [3:0]  hstrb_out,
  input  logic [31:0] hrdata_in,
  input  logic        hready_in,
  input  logic        hresp_in
);

  localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);

  logic        clk, rst;
  state_e      state_q;
  owner_e      own_q;
  logic [3:0]  starve_q;
  logic [31:0] wdata_q;
  logic        grant_i;
  logic        done;
  logic        expire;

  assign clk = ma_riscv32_rp_clk_in;
  assign rst = ms_riscv32_mp_rst_in;

  // Fetch wins when alone, or when it has been passed over STARVE_LIMIT times.
  assign grant_i = i_req_in && (!d_req_in || (starve_q == SLIM));

  assign done = (state_q == DATA) && (hready_in || expire);

  merv32_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     ((state_q == DATA) && !hready_in),
    .clr_i    (done),
    .expire_o (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      own_q        <= OWN_I;
      starve_q     <= '0;
      wdata_q      <= '0;
      haddr_out    <= '0;
      htrans_out   <= HTRANS_IDLE;
      hwrite_out   <= 1'b0;
      hwdata_out   <= '0;
      hstrb_out    <= '0;
      i_rdata_out  <= '0;
      i_hready_out <= 1'b0;
      i_err_out    <= 1'b0;
      d_rdata_out  <= '0;
      d_hready_out <= 1'b0;
      d_err_out    <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses.
      i_hready_out <= 1'b0;
      i_err_out    <= 1'b0;
      d_hready_out <= 1'b0;
      d_err_out    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req_in || d_req_in) begin
            state_q    <= ADDR;
            htrans_out <= HTRANS_NONSEQ;
            if (grant_i) begin
              own_q      <= OWN_I;
              haddr_out  <= i_addr_in;
              hwrite_out <= 1'b0;
              hstrb_out  <= 4'hF;
              wdata_q    <= '0;
              starve_q   <= '0;
            end else begin
              own_q      <= OWN_D;
              haddr_out  <= d_addr_in;
              hwrite_out <= d_wr_in;
              hstrb_out  <= d_mask_in;
              wdata_q    <= d_wr_in ? d_wdata_in : 32'h0;
              // Only a data grant that beat a waiting fetch counts as starvation.
              if (i_req_in) starve_q <= (starve_q == SLIM) ? SLIM : starve_q + 4'd1;
              else          starve_q <= '0;
            end
          end
        end
        ADDR: begin
          state_q    <= DATA;
          htrans_out <= HTRANS_IDLE;
          hwdata_out <= wdata_q;
        end
        DATA: begin
          if (done) begin
            state_q <= IDLE;
            // A watchdog expiry reports an error and leaves rdata untouched.
            if (own_q == OWN_I) begin
              i_hready_out <= 1'b1;
              i_err_out    <= hready_in ? hresp_in : 1'b1;
              if (hready_in) i_rdata_out <= hrdata_in;
            end else begin
              d_hready_out <= 1'b1;
              d_err_out    <= hready_in ? hresp_in : 1'b1;
              if (hready_in && !hwrite_out) d_rdata_out <= hrdata_in;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
